// File: rtl/hazard_tracker_pkg.sv
// Shared encodings and stage-record layout for the hazard/forwarding controller.
// Pure declarations: no latency, no flow control.
package hazard_tracker_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int REC_RW = 4;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              vld;
    logic [REC_RW-1:0] dst;
    logic              we;
    logic              load;
  } stage_rec_t;
endpackage

// File: rtl/hazard_tracker_if.sv
// Decode/execute side of the hazard controller: operand info in, selects/stalls/flushes out.
// The core drives the master side; the tracker answers combinationally on the slave side.
interface hazard_tracker_if #(
  parameter int NUM_SRC = 3,
  parameter int RW      = 4
);
  logic [NUM_SRC*RW-1:0] src_d;
  logic [NUM_SRC-1:0]    src_vld_d;
  logic [RW-1:0]         dst_d;
  logic                  we_d;
  logic                  load_d;
  logic                  mcyc_d;
  logic                  branch_taken_e;
  logic [2*NUM_SRC-1:0]  fwd_sel_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic                  busy_e;

  modport master (
    output src_d, src_vld_d, dst_d, we_d, load_d, mcyc_d, branch_taken_e,
    input  fwd_sel_e, stall_f, stall_d, flush_d, flush_e, busy_e
  );

  modport slave (
    input  src_d, src_vld_d, dst_d, we_d, load_d, mcyc_d, branch_taken_e,
    output fwd_sel_e, stall_f, stall_d, flush_d, flush_e, busy_e
  );
endinterface

// File: rtl/hazard_stage_rec.sv
// One pipeline-stage destination record; clear beats hold, hold beats load.
// One-cycle register, async active-low reset to an invalid record.
module hazard_stage_rec
  import hazard_tracker_pkg::*;
#(
  parameter type rec_t = stage_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_hold,
  input  logic i_clear,
  input  rec_t i_d,
  output rec_t o_q
);
  rec_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/hazard_tracker.sv
// E/M/W destination scoreboard producing forward selects, load-use/multi-cycle stalls and branch flushes.
// Outputs are combinational from registered records and decode inputs; records advance every clk unless held.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int RW      = 4,
  parameter int MUL_LAT = 3,
  parameter int PC_REG  = 15
) (
  input  logic           clk,
  input  logic           reset,
  hazard_tracker_if.slave bus
);
  typedef struct packed {
    logic          vld;
    logic [RW-1:0] dst;
    logic          we;
    logic          load;
  } rec_t;

  localparam logic [RW-1:0]    PC_ADDR  = RW'(PC_REG);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rec_t                  w_d_rec, w_e, w_m, w_w;
  logic [NUM_SRC*RW-1:0] r_src_e;
  logic [NUM_SRC-1:0]    r_src_vld_e;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*NUM_SRC-1:0]  w_fwd;
  logic                  w_br, w_busy, w_lu, w_hold_e, w_flush_e;

  // Gated by reset so every output is quiet while the core is held in reset.
  assign w_br      = bus.branch_taken_e & reset;
  assign w_busy    = (r_cnt != '0);
  assign w_hold_e  = w_busy & ~w_br;
  assign w_flush_e = w_br | (w_lu & ~w_busy);

  // R15 is never a scoreboard destination, so nothing can forward or stall on it.
  assign w_d_rec = '{vld: 1'b1, dst: bus.dst_d, we: bus.we_d & (bus.dst_d != PC_ADDR), load: bus.load_d};

  always_comb begin
    w_lu = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_vld_d[i] && (bus.src_d[i*RW +: RW] != PC_ADDR) &&
          w_e.vld && w_e.we && w_e.load && (w_e.dst == bus.src_d[i*RW +: RW])) begin
        w_lu = 1'b1;
      end
    end
  end

  always_comb begin
    w_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_src_vld_e[i] && (r_src_e[i*RW +: RW] != PC_ADDR)) begin
        if (w_m.vld && w_m.we && (w_m.dst == r_src_e[i*RW +: RW])) begin
          w_fwd[2*i +: 2] = FWD_M;
        end else if (w_w.vld && w_w.we && (w_w.dst == r_src_e[i*RW +: RW])) begin
          w_fwd[2*i +: 2] = FWD_W;
        end else begin
          w_fwd[2*i +: 2] = FWD_RF;
        end
      end
    end
  end

  // A held multi-cycle op stays in E while M is fed bubbles.
  hazard_stage_rec #(.rec_t(rec_t)) u_rec_e (
    .clk(clk), .rst_n(reset), .i_hold(w_hold_e), .i_clear(w_flush_e), .i_d(w_d_rec), .o_q(w_e)
  );
  hazard_stage_rec #(.rec_t(rec_t)) u_rec_m (
    .clk(clk), .rst_n(reset), .i_hold(1'b0), .i_clear(w_hold_e), .i_d(w_e), .o_q(w_m)
  );
  hazard_stage_rec #(.rec_t(rec_t)) u_rec_w (
    .clk(clk), .rst_n(reset), .i_hold(1'b0), .i_clear(1'b0), .i_d(w_m), .o_q(w_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src_e     <= '0;
      r_src_vld_e <= '0;
      r_cnt       <= '0;
    end else if (w_flush_e) begin
      r_src_e     <= '0;
      r_src_vld_e <= '0;
      r_cnt       <= '0;
    end else if (w_hold_e) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_src_e     <= bus.src_d;
      r_src_vld_e <= bus.src_vld_d;
      r_cnt       <= bus.mcyc_d ? CNT_LOAD : '0;
    end
  end

  assign bus.fwd_sel_e = w_fwd;
  assign bus.stall_f   = ~w_br & (w_lu | w_busy);
  assign bus.stall_d   = ~w_br & (w_lu | w_busy);
  assign bus.flush_d   = w_br;
  assign bus.flush_e   = w_flush_e;
  assign bus.busy_e    = w_busy;
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed cycle-by-cycle program for hazard_tracker; expected outputs queued per cycle
// and checked by an independent monitor on the falling edge.
module tb_hazard_tracker;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hazard_tracker_if #(.NUM_SRC(3), .RW(4)) hif ();

  hazard_tracker #(.NUM_SRC(3), .RW(4), .MUL_LAT(3), .PC_REG(15)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (hif.slave)
  );

  typedef struct {
    string      name;
    logic [5:0] fwd;
    logic [4:0] flg;   // {stall_f, stall_d, flush_d, flush_e, busy_e}
  } exp_t;

  exp_t q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : monitor
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e, hif.busy_e};
        n_tests++;
        if ((hif.fwd_sel_e !== e.fwd) || (act !== e.flg)) begin
          n_fail++;
          $display("FAIL %s: got fwd=%b flags=%b, expected fwd=%b flags=%b",
                   e.name, hif.fwd_sel_e, act, e.fwd, e.flg);
        end
      end
    end
  end

  task automatic drv(input string nm, input logic rst,
                     input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [2:0] v, input logic [3:0] dst,
                     input logic we, input logic ld, input logic mc, input logic br,
                     input logic [5:0] efwd, input logic [4:0] eflg);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n              = rst;
    hif.src_d          = {s2, s1, s0};
    hif.src_vld_d      = v;
    hif.dst_d          = dst;
    hif.we_d           = we;
    hif.load_d         = ld;
    hif.mcyc_d         = mc;
    hif.branch_taken_e = br;
    e.name = nm;
    e.fwd  = efwd;
    e.flg  = eflg;
    q.push_back(e);
  endtask

  task automatic nop(input string nm, input logic [5:0] efwd, input logic [4:0] eflg);
    drv(nm, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, efwd, eflg);
  endtask

  initial begin : stimulus
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    hif.src_d = '0; hif.src_vld_d = '0; hif.dst_d = '0;
    hif.we_d = 1'b0; hif.load_d = 1'b0; hif.mcyc_d = 1'b0; hif.branch_taken_e = 1'b0;

    // reset: decode inputs active, all outputs must stay 0
    drv("reset",       1'b0, 4'd2, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 5'b00000);
    // back-to-back: ADD r2<-r1,r3 ; SUB r4<-r2,r5
    drv("b2b_add",     1'b1, 4'd1, 4'd3, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("b2b_sub_d",   1'b1, 4'd2, 4'd5, 4'd0, 3'b011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("b2b_fwd_m",   6'b000010, 5'b00000);
    nop("b2b_drain",   6'b000000, 5'b00000);
    // distance 2: ADD r2 ; NOP ; ORR r6<-r2
    drv("d2_add",      1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("d2_gap",      6'b000000, 5'b00000);
    drv("d2_orr_d",    1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("d2_fwd_w",    6'b000001, 5'b00000);
    // M and W both write r2: M wins, on operands 0 and 2
    drv("mw_mov1",     1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("mw_mov2",     1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("mw_orr_d",    1'b1, 4'd2, 4'd0, 4'd2, 3'b101, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("mw_m_wins",   6'b100010, 5'b00000);
    // load-use: LDR r7 ; ADD r8<-r7,r1 (held one cycle in D)
    drv("lu_ldr",      1'b1, 4'd0, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("lu_stall",    1'b1, 4'd7, 4'd1, 4'd0, 3'b011, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b11010);
    drv("lu_release",  1'b1, 4'd7, 4'd1, 4'd0, 3'b011, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("lu_fwd_w",    6'b000001, 5'b00000);
    nop("mc_gap",      6'b000000, 5'b00000);
    // multi-cycle: MUL r9<-r9,r2 ; AND r10<-r9 (held while busy)
    drv("mc_mul",      1'b1, 4'd9, 4'd2, 4'd0, 3'b011, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000, 5'b00000);
    drv("mc_busy1",    1'b1, 4'd9, 4'd0, 4'd0, 3'b001, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b11001);
    drv("mc_busy2_mbub", 1'b1, 4'd9, 4'd0, 4'd0, 3'b001, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b11001);
    drv("mc_release",  1'b1, 4'd9, 4'd0, 4'd0, 3'b001, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("mc_fwd_m",    6'b000010, 5'b00000);
    // branch resolved while a load-use condition exists
    drv("br_ldr",      1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("br_over_lu",  1'b1, 4'd3, 4'd0, 4'd0, 3'b001, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000000, 5'b00110);
    nop("br_after",    6'b000000, 5'b00000);
    // R15 as destination and source
    drv("pc_mov",      1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("pc_src_d",    1'b1, 4'd15, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("pc_no_fwd",   6'b000000, 5'b00000);
    drv("pc_ldr",      1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("pc_no_lu",    1'b1, 4'd15, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    // reset pulsed in the middle of a multi-cycle hold
    drv("rst_mul",     1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000, 5'b00000);
    nop("rst_busy",    6'b000000, 5'b11001);
    drv("rst_mid_hold", 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    drv("rst_hold",    1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);
    nop("rst_release", 6'b000000, 5'b00000);
    drv("post_rst",    1'b1, 4'd9, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Parametrised hazard/forwarding controller for the pipelined ARM-style core (F/D/E/M/W).
- Replaces ad-hoc per-operand match logic scattered through the datapath.
- Keeps its own registered E/M/W destination scoreboard and produces forward selects, stalls and flushes.
- Adds behaviour the current core lacks: N source operands, load-use stall, a multi-cycle execute unit with a hold counter, branch flush priority, and PC-register forwarding exclusion.

Parameters:
- NUM_SRC, 3, number of source operands tracked per instruction (Rn, Rm, Rs/Rd-store).
- RW, 4, register address width.
- MUL_LAT, 3, cycles a multi-cycle op occupies E (legal range 1..15; 1 means single-cycle).
- PC_REG, 15, register index that is never forwarded or scoreboarded.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- src_d  in  NUM_SRC*RW  decode-stage source addresses, operand i at [i*RW +: RW]
- src_vld_d  in  NUM_SRC  operand i actually read by the decode instruction
- dst_d  in  RW  decode-stage destination (WA3D)
- we_d  in  1  decode instruction writes a register
- load_d  in  1  decode instruction is a load (MemtoReg)
- mcyc_d  in  1  decode instruction uses the multi-cycle unit
- branch_taken_e  in  1  PCSrc resolved in E
- fwd_sel_e  out  2*NUM_SRC  per-operand select: 00 regfile, 01 ResultW, 10 ALUOutM
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_d  out  1  clear F/D register
- flush_e  out  1  clear D/E register (bubble into E)
- busy_e  out  1  multi-cycle op holding E

Behaviour:
- Reset (reset=0, async): all stage records invalid, counter=0; every output 0.
- Internal records, each {vld, dst, we, load}: E, M, W. E also holds src/src_vld registered from D.
- Advance each clk when not held:
  - D→E: D fields, or a bubble when flush_e or a load-use stall is active.
  - E→M, M→W.
- Counter:
  - Loaded with MUL_LAT-1 when an mcyc instruction enters E (0 when MUL_LAT=1).
  - While counter≠0: E record holds, counter decrements, M receives a bubble, busy_e=1.
  - The op moves to M on the cycle the counter reads 0.
- Forwarding (combinational from records):
  - For operand i with E.src_vld[i]=1 and src≠PC_REG: 10 if M.vld&M.we&M.dst==src; else 01 if W.vld&W.we&W.dst==src; else 00.
  - M has priority over W.
- Load-use stall (lu):
  - Set if any D operand i has src_vld_d[i]=1, src≠PC_REG, E.vld&E.we&E.load, and E.dst==src.
  - Effect: stall_f=stall_d=1 and flush_e=1 for exactly one cycle; the dependent instruction is then forwarded from W.
- Multi-cycle hold: busy_e=1 forces stall_f=stall_d=1 and blocks D→E. No flush_e; E is held, not cleared.
- Branch (highest priority): branch_taken_e=1 gives flush_d=1, flush_e=1, stall_f=0, stall_d=0, overriding lu.
- Branch vs busy:
  - A branch cannot be resolved in E while busy_e=1, because mcyc ops are never branches.
  - If both assert anyway, the branch wins and the counter clears.
- Destination PC_REG: the record keeps we=0, so there is no forwarding and no stall on R15.
- A record with vld=0 never matches.
- Reset asserted mid-hold clears the counter and records immediately.

Decomposition:
- Shared package: fwd_sel encodings (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and the stage-record struct/field widths.
- One natural sub-module: hazard_stage_rec (a single {vld,dst,we,load} register with hold/clear and async active-low reset), instantiated for E, M and W.

Test Plan:
- Back-to-back dependency:
  - Stimulus: ADD r2←r1,r3 then SUB r4←r2,r5.
  - Response: in the cycle SUB is in E, fwd_sel_e operand0=10, no stall.
- Distance-2 dependency:
  - Stimulus: ADD r2; NOP; ORR r6←r2.
  - Response: operand0 select 01. With both M and W writing r2, M wins (10).
- Load-use:
  - Stimulus: LDR r7 then ADD r8←r7.
  - Response: one cycle with stall_f=stall_d=flush_e=1; next cycle fwd select 01; total 1 bubble.
- Multi-cycle, MUL_LAT=3:
  - Stimulus: MUL r9 then AND r10←r9.
  - Response: busy_e=1 for 2 cycles with stall_f=stall_d=1; AND then forwards 10; the M stage sees 2 bubbles.
- Branch during load-use:
  - Stimulus: branch_taken_e=1 in the same cycle a lu condition exists.
  - Response: flush_d=flush_e=1, stall_f=stall_d=0.
- R15 and reset:
  - Stimulus: source r15 while M.dst=15 with we_d=1. Response: select 00, no stall.
  - Stimulus: reset pulsed low mid-MUL hold. Response: busy_e=0 and all outputs 0 immediately.
